uart_tx_buf: RTL and testbench

//   Buffered UART transmit path: byte-wide write port into a small FIFO, drained by a

---
 rtl/uart_tx_buf_pkg.sv | 17 +
 rtl/uart_tx_buf_if.sv | 18 +
 rtl/uart_tx_buf_fifo.sv | 57 +++++
 rtl/uart_tx_buf.sv | 148 ++++++++++++++
 tb/tb_uart_tx_buf.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_buf_pkg.sv
// Shared types and default constants for the buffered UART transmitter.
package uart_tx_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int DEF_WIDTH_DATA = 8;
  localparam int DEF_NB_STOP    = 2;
  localparam int DEF_WIDTH_CLK  = 9;
  localparam int DEF_CLK_SIZE   = 434;   // 50 MHz / 115200
  localparam int DEF_DEPTH_LOG  = 2;

endpackage

// File: rtl/uart_tx_buf_if.sv
// Producer-side write port and line/status signals of uart_tx_buf.
interface uart_tx_buf_if
  import uart_tx_buf_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA
) ();

  logic                  we;
  logic [WIDTH_DATA-1:0] data;
  logic                  full;
  logic                  mty;
  logic                  idle;
  logic                  tx;

  modport master (output we, data, input full, mty, idle, tx);
  modport slave  (input we, data, output full, mty, idle, tx);

endinterface

// File: rtl/uart_tx_buf_fifo.sv
// Small synchronous FIFO; full/empty come from the registered occupancy count,
// so a write while full is dropped even if a pop happens in the same cycle.
module uart_tx_buf_fifo
  import uart_tx_buf_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH_DATA,
  parameter int DEPTH_LOG = DEF_DEPTH_LOG
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG;
  localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap modulo depth; count tracks occupancy.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
      if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (DEPTH_LOG + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO drained by an 8N<NB_STOP> serializer with its
// own baud counter. Back-to-back queued bytes go out with no idle gap.
//
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for one bit time
//   DATA  | data bits, LSB first, one bit time each
//   STOP  | stop bit(s) high, then next START or IDLE
module uart_tx_buf
  import uart_tx_buf_pkg::*;
#(
  parameter int WIDTH_DATA = DEF_WIDTH_DATA,
  parameter int NB_STOP    = DEF_NB_STOP,
  parameter int WIDTH_CLK  = DEF_WIDTH_CLK,
  parameter int CLK_SIZE   = DEF_CLK_SIZE,
  parameter int DEPTH_LOG  = DEF_DEPTH_LOG
) (
  input logic           clk,
  input logic           nrst,
  uart_tx_buf_if.slave  bus
);

  localparam int BW = $clog2(WIDTH_DATA + 1);
  localparam logic [WIDTH_CLK-1:0] BAUD_LAST = WIDTH_CLK'(CLK_SIZE - 1);
  localparam logic [BW-1:0]        DATA_LAST = BW'(WIDTH_DATA - 1);
  localparam logic [BW-1:0]        STOP_LAST = BW'(NB_STOP - 1);

  tx_state_t             state_q, state_d;
  logic [WIDTH_CLK-1:0]  baud_q;
  logic [BW-1:0]         bit_q, bit_d;
  logic [WIDTH_DATA-1:0] shift_q, shift_d;
  logic                  tx_q, tx_d;
  logic                  pop;
  logic                  bit_end;
  logic [WIDTH_DATA-1:0] fifo_data;
  logic                  fifo_full;
  logic                  fifo_empty;

  uart_tx_buf_fifo #(
    .WIDTH     (WIDTH_DATA),
    .DEPTH_LOG (DEPTH_LOG)
  ) u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .push      (bus.we),
    .push_data (bus.data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bit_end  = (baud_q == BAUD_LAST);
  assign bus.full = fifo_full;
  assign bus.mty  = fifo_empty;
  assign bus.idle = fifo_empty && (state_q == ST_IDLE);
  assign bus.tx   = tx_q;

  // Next-state, shift/bit-count and line-level decisions.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_data;
          tx_d    = 1'b0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            tx_d    = 1'b1;
            bit_d   = '0;
            state_d = ST_STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BW'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = fifo_data;
              tx_d    = 1'b0;
              state_d = ST_START;
            end else begin
              tx_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, shift register and registered line output; reset forces the line high.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  // Baud counter: held at zero while idle, wraps at each bit boundary.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      baud_q <= '0;
    end else if (state_q == ST_IDLE || bit_end) begin
      baud_q <= '0;
    end else begin
      baud_q <= baud_q + WIDTH_CLK'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: a default-rate instance (434 clk/bit, 2 stop)
// and a fast instance (4 clk/bit, 1 stop); a line decoder per instance collects
// received bytes and start-bit times.
module tb_uart_tx_buf;
  import uart_tx_buf_pkg::*;

  localparam int CA = 434;
  localparam int CB = 4;
  localparam int FA = (1 + 8 + 2) * CA;   // 4774
  localparam int FB = (1 + 8 + 1) * CB;   // 40

  logic clk = 1'b0;
  logic nrst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ferr_a = 0;
  int   ferr_b = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int   t_a[$];
  int   t_b[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_buf_if #(.WIDTH_DATA(8)) bus_a ();
  uart_tx_buf_if #(.WIDTH_DATA(8)) bus_b ();

  uart_tx_buf #(.WIDTH_DATA(8), .NB_STOP(2), .WIDTH_CLK(9), .CLK_SIZE(CA), .DEPTH_LOG(2))
    dut_a (.clk(clk), .nrst(nrst), .bus(bus_a));

  uart_tx_buf #(.WIDTH_DATA(8), .NB_STOP(1), .WIDTH_CLK(2), .CLK_SIZE(CB), .DEPTH_LOG(2))
    dut_b (.clk(clk), .nrst(nrst), .bus(bus_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic line(input int sel);
    return (sel == 0) ? bus_a.tx : bus_b.tx;
  endfunction

  // Expected line level k cycles after the write edge into an idle block.
  function automatic logic exp_line(input int k, input int c, input logic [7:0] b);
    int bi;
    if (k < 1) return 1'b1;
    bi = (k - 1) / c;
    if (bi == 0) return 1'b0;
    if (bi <= 8) return b[bi-1];
    return 1'b1;
  endfunction

  task automatic mon(input int sel, input int c);
    logic [7:0] b;
    int ts;
    forever begin
      @(negedge clk);
      if (nrst === 1'b1 && line(sel) === 1'b0) begin
        ts = cyc;
        repeat (c / 2) @(negedge clk);
        if (line(sel) === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (c) @(negedge clk);
            b[i] = line(sel);
          end
          repeat (c) @(negedge clk);
          if (line(sel) === 1'b1) begin
            if (sel == 0) begin q_a.push_back(b); t_a.push_back(ts); end
            else          begin q_b.push_back(b); t_b.push_back(ts); end
          end else begin
            if (sel == 0) ferr_a++; else ferr_b++;
          end
        end
      end
    end
  endtask

  initial mon(0, CA);
  initial mon(1, CB);

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    bus_a.we = 1'b0; bus_a.data = 8'h00;
    bus_b.we = 1'b0; bus_b.data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_tx_a",   bus_a.tx,   1'b1);
    check("rst_full_a", bus_a.full, 1'b0);
    check("rst_mty_a",  bus_a.mty,  1'b1);
    check("rst_idle_a", bus_a.idle, 1'b1);
    check("rst_tx_b",   bus_b.tx,   1'b1);
    check("rst_full_b", bus_b.full, 1'b0);
    check("rst_mty_b",  bus_b.mty,  1'b1);
    check("rst_idle_b", bus_b.idle, 1'b1);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // single 0xA5 frame, exact cycle-by-cycle line and status
    bus_a.we = 1'b1; bus_a.data = 8'hA5;
    @(negedge clk);
    bus_a.we = 1'b0;
    for (int k = 0; k <= FA + 3; k++) begin
      if (k > 0) @(negedge clk);
      check("t1_tx",   bus_a.tx,   exp_line(k, CA, 8'hA5));
      check("t1_idle", bus_a.idle, (k >= FA + 1) ? 1'b1 : 1'b0);
      check("t1_mty",  bus_a.mty,  (k == 0) ? 1'b0 : 1'b1);
    end
    check("t1_rx_n",    q_a.size(), 1);
    check("t1_rx_byte", q_a[0],     8'hA5);

    // three back-to-back bytes, no idle gap between frames
    q_a.delete(); t_a.delete();
    bus_a.we = 1'b1; bus_a.data = 8'h00;
    @(negedge clk); bus_a.data = 8'hFF;
    @(negedge clk); bus_a.data = 8'h55;
    @(negedge clk); bus_a.we = 1'b0;
    repeat (3 * FA + 200) @(negedge clk);
    check("t2_rx_n", q_a.size(), 3);
    check("t2_b0",   q_a[0], 8'h00);
    check("t2_b1",   q_a[1], 8'hFF);
    check("t2_b2",   q_a[2], 8'h55);
    check("t2_gap1", t_a[1] - t_a[0], FA);
    check("t2_gap2", t_a[2] - t_a[1], FA);
    check("t2_idle", bus_a.idle, 1'b1);

    // reset in the middle of a data bit (0x3C bit1 = 0), then clean 0x81
    bus_a.we = 1'b1; bus_a.data = 8'h3C;
    @(negedge clk); bus_a.we = 1'b0;
    repeat (1100) @(negedge clk);
    check("t4_pre_tx", bus_a.tx, 1'b0);
    nrst = 1'b0;
    #1;
    check("t4_tx",   bus_a.tx,   1'b1);
    check("t4_mty",  bus_a.mty,  1'b1);
    check("t4_idle", bus_a.idle, 1'b1);
    check("t4_full", bus_a.full, 1'b0);
    @(negedge clk); nrst = 1'b1;
    repeat (5000) @(negedge clk);
    q_a.delete(); t_a.delete();
    bus_a.we = 1'b1; bus_a.data = 8'h81;
    @(negedge clk); bus_a.we = 1'b0;
    repeat (FA + 200) @(negedge clk);
    check("t4_rx_n",    q_a.size(), 1);
    check("t4_rx_byte", q_a[0],     8'h81);
    check("t4_idle2",   bus_a.idle, 1'b1);

    // fast instance: 0x01, 40-cycle frame, LSB first
    q_b.delete(); t_b.delete();
    bus_b.we = 1'b1; bus_b.data = 8'h01;
    @(negedge clk); bus_b.we = 1'b0;
    for (int k = 0; k <= FB + 3; k++) begin
      if (k > 0) @(negedge clk);
      check("t5_tx",   bus_b.tx,   exp_line(k, CB, 8'h01));
      check("t5_idle", bus_b.idle, (k >= FB + 1) ? 1'b1 : 1'b0);
    end
    check("t5_rx_n",    q_b.size(), 1);
    check("t5_rx_byte", q_b[0],     8'h01);

    // six consecutive writes: 5 accepted, 6th dropped on full
    q_b.delete(); t_b.delete();
    bus_b.we = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_b.data = 8'(8'h10 + i);
      @(negedge clk);
      if (i == 3) check("t3_not_full", bus_b.full, 1'b0);
      if (i >= 4) check("t3_full",     bus_b.full, 1'b1);
    end
    bus_b.we = 1'b0;
    repeat (5 * FB + 40) @(negedge clk);
    check("t3_rx_n", q_b.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("t3_byte", q_b[i], 8'(8'h10 + i));
      if (i > 0) check("t3_gap", t_b[i] - t_b[i-1], FB);
    end
    check("t3_idle", bus_b.idle, 1'b1);

    // push coinciding with pop at count 2 keeps count at 2
    q_b.delete(); t_b.delete();
    bus_b.we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_b.data = 8'(8'h20 + i);
      @(negedge clk);
    end
    bus_b.we = 1'b0;
    repeat (38) @(negedge clk);
    check("t6_pre_full", bus_b.full, 1'b0);
    check("t6_pre_mty",  bus_b.mty,  1'b0);
    bus_b.we = 1'b1; bus_b.data = 8'h23;
    @(negedge clk);
    check("t6_same_full", bus_b.full, 1'b0);
    check("t6_same_mty",  bus_b.mty,  1'b0);
    bus_b.data = 8'h24;
    @(negedge clk);
    check("t6_cnt3_full", bus_b.full, 1'b0);
    bus_b.data = 8'h25;
    @(negedge clk);
    bus_b.we = 1'b0;
    check("t6_cnt4_full", bus_b.full, 1'b1);
    repeat (6 * FB + 40) @(negedge clk);
    check("t6_rx_n", q_b.size(), 6);
    for (int i = 0; i < 6; i++) check("t6_byte", q_b[i], 8'(8'h20 + i));

    check("ferr_a", ferr_a, 0);
    check("ferr_b", ferr_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
